dipswitch: RTL and testbench

- Captures two 3-digit BCD operands entered digit by digit from a 4-bit DIP switch, one digit per button press.
- Digits shift in from the right, so the first digit entered becomes the most significant.
- The first number fills first, then the second; the block then locks until reset.
- Sits between the board switch/button inputs and the downstream arithmetic and display logic.

---
 rtl/dipswitch.sv | 121 ++++++++++++
 tb/tb_dipswitch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dipswitch.sv
// dipswitch: captures two DIGITS-wide packed-BCD operands, one digit per
// button press from a 4-bit DIP switch ({ag,bg,cg,dg}), then locks.
// Ports: clk, rst (sync, active-low), ag/bg/cg/dg (digit MSB..LSB),
//   button (level, rising edge = enter), first_num / second_num (registered).
// Optional: define DIPSWITCH_BUTTON_SYNC_EN to add 2-flop synchronizers on
//   button and switches (adds 2 clk of press-to-output latency).
module dipswitch #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ag,
  input  logic                  bg,
  input  logic                  cg,
  input  logic                  dg,
  input  logic                  button,
  output logic [4*DIGITS-1:0]   first_num,
  output logic [4*DIGITS-1:0]   second_num
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_FIRST,
    S_SECOND,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [W-1:0]    first_q;
  logic [W-1:0]    second_q;
  logic            button_q;

  logic            btn_s;
  logic [3:0]      digit;
  logic            press;
  logic            valid;
  logic            last;

`ifdef DIPSWITCH_BUTTON_SYNC_EN
  // Switches ride the same two-stage chain as the button so the digit
  // seen at the detected edge is the one present when it was pressed.
  logic [1:0]      btn_sync_q;
  logic [3:0]      sw_s1_q;
  logic [3:0]      sw_s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_sync_q <= 2'b00;
      sw_s1_q    <= 4'h0;
      sw_s2_q    <= 4'h0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], button};
      sw_s1_q    <= {ag, bg, cg, dg};
      sw_s2_q    <= sw_s1_q;
    end
  end

  assign btn_s = btn_sync_q[1];
  assign digit = sw_s2_q;
`else
  assign btn_s = button;
  assign digit = {ag, bg, cg, dg};
`endif

  assign press = btn_s & ~button_q;
  assign valid = press && (digit <= 4'd9);
  assign last  = (count_q == CW'(DIGITS - 1));

  // Shift left by one nibble; the size cast drops the old top digit
  // and keeps DIGITS=1 legal.
  function automatic logic [W-1:0] shift_in(
    input logic [W-1:0] cur,
    input logic [3:0]   d
  );
    return W'({cur, d});
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FIRST;
      count_q  <= '0;
      first_q  <= '0;
      second_q <= '0;
      button_q <= 1'b0;
    end else begin
      button_q <= btn_s;
      if (valid) begin
        case (state_q)
          S_FIRST: begin
            first_q <= shift_in(first_q, digit);
            if (last) begin
              count_q <= '0;
              state_q <= S_SECOND;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          S_SECOND: begin
            second_q <= shift_in(second_q, digit);
            if (last) begin
              count_q <= '0;
              state_q <= S_DONE;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          default: begin
            state_q <= S_DONE;
          end
        endcase
      end
    end
  end

  assign first_num  = first_q;
  assign second_num = second_q;

endmodule

// File: tb/tb_dipswitch.sv
// tb_dipswitch: directed and randomized checks of dipswitch against a
// digit-count reference model of the two operands.
module tb_dipswitch;

  localparam int D    = 3;
  localparam int W    = 4 * D;
  localparam int MASK = (1 << W) - 1;
`ifdef DIPSWITCH_BUTTON_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ag = 1'b0, bg = 1'b0, cg = 1'b0, dg = 1'b0;
  logic         button = 1'b0;
  logic [W-1:0] first_num, second_num;

  int n_checks = 0;
  int n_err    = 0;

  int m_first, m_second, n1, n2;

  dipswitch #(.DIGITS(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .ag         (ag),
    .bg         (bg),
    .cg         (cg),
    .dg         (dg),
    .button     (button),
    .first_num  (first_num),
    .second_num (second_num)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_first = 0; m_second = 0; n1 = 0; n2 = 0;
  endtask

  // Operand semantics: first D valid digits go to first, next D to
  // second, everything after is ignored; each is a base-16 shift.
  task automatic model_press(input int d);
    if (d <= 9) begin
      if (n1 < D) begin
        m_first = (m_first * 16 + d) & MASK;
        n1++;
      end else if (n2 < D) begin
        m_second = (m_second * 16 + d) & MASK;
        n2++;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    button = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic drive_press(input logic [3:0] d, input int hold);
    @(negedge clk);
    {ag, bg, cg, dg} = d;
    button = 1'b1;
    repeat (hold) @(negedge clk);
    button = 1'b0;
    repeat (EXTRA) @(negedge clk);
    model_press(int'(d));
  endtask

  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    n_checks++;
    if (first_num !== 12'h000) begin
      n_err++;
      $display("FAIL reset_first got=%h exp=000", first_num);
    end
    n_checks++;
    if (second_num !== 12'h000) begin
      n_err++;
      $display("FAIL reset_second got=%h exp=000", second_num);
    end
  endtask

  task automatic test_first_operand();
    drive_press(4'd1, 1);
    n_checks++;
    if (first_num !== 12'h001) begin
      n_err++;
      $display("FAIL first_d1 got=%h exp=001", first_num);
    end
    drive_press(4'd2, 1);
    drive_press(4'd3, 1);
    n_checks++;
    if (first_num !== 12'h123) begin
      n_err++;
      $display("FAIL first_op got=%h exp=123", first_num);
    end
    n_checks++;
    if (second_num !== 12'h000) begin
      n_err++;
      $display("FAIL first_op_second got=%h exp=000", second_num);
    end
  endtask

  task automatic test_second_operand();
    drive_press(4'd4, 1);
    drive_press(4'd5, 1);
    drive_press(4'd6, 1);
    n_checks++;
    if (second_num !== 12'h456) begin
      n_err++;
      $display("FAIL second_op got=%h exp=456", second_num);
    end
    n_checks++;
    if (first_num !== 12'h123) begin
      n_err++;
      $display("FAIL second_op_first got=%h exp=123", first_num);
    end
  endtask

  task automatic test_done_lock();
    drive_press(4'd5, 1);
    drive_press(4'd6, 1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (first_num !== 12'h123) begin
      n_err++;
      $display("FAIL done_first got=%h exp=123", first_num);
    end
    n_checks++;
    if (second_num !== 12'h456) begin
      n_err++;
      $display("FAIL done_second got=%h exp=456", second_num);
    end
  endtask

  task automatic test_invalid_held();
    do_reset(1);
    drive_press(4'd12, 1);
    @(negedge clk);
    n_checks++;
    if (first_num !== 12'h000) begin
      n_err++;
      $display("FAIL invalid_digit got=%h exp=000", first_num);
    end
    drive_press(4'd7, 5);
    n_checks++;
    if (first_num !== 12'h007) begin
      n_err++;
      $display("FAIL held_press got=%h exp=007", first_num);
    end
    drive_press(4'd8, 1);
    n_checks++;
    if (first_num !== 12'h078) begin
      n_err++;
      $display("FAIL after_held got=%h exp=078", first_num);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    drive_press(4'd9, 1);
    drive_press(4'd9, 1);
    n_checks++;
    if (first_num !== 12'h099) begin
      n_err++;
      $display("FAIL mid_pre got=%h exp=099", first_num);
    end
    do_reset(1);
    @(negedge clk);
    n_checks++;
    if (first_num !== 12'h000 || second_num !== 12'h000) begin
      n_err++;
      $display("FAIL mid_reset got=%h/%h exp=000/000",
               first_num, second_num);
    end
    // Three more digits must all land in first: count restarted.
    drive_press(4'd1, 1);
    n_checks++;
    if (first_num !== 12'h001) begin
      n_err++;
      $display("FAIL mid_after got=%h exp=001", first_num);
    end
    drive_press(4'd2, 1);
    drive_press(4'd3, 1);
    drive_press(4'd4, 1);
    n_checks++;
    if (first_num !== 12'h123 || second_num !== 12'h004) begin
      n_err++;
      $display("FAIL mid_count got=%h/%h exp=123/004",
               first_num, second_num);
    end
  endtask

  task automatic test_button_through_reset();
    @(negedge clk);
    rst = 1'b0;
    {ag, bg, cg, dg} = 4'd5;
    button = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (1 + EXTRA) @(negedge clk);
    model_press(5);
    button = 1'b0;
    n_checks++;
    if (first_num !== W'(m_first)) begin
      n_err++;
      $display("FAIL held_reset got=%h exp=%h", first_num, W'(m_first));
    end
  endtask

  task automatic test_random();
    int d;
    do_reset(1);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        do_reset($urandom_range(1, 2));
        @(negedge clk);
      end else begin
        if ($urandom_range(0, 3) == 0) d = $urandom_range(10, 15);
        else d = $urandom_range(0, 9);
        drive_press(4'(d), $urandom_range(1, 3));
        // Switch noise with no press must be ignored.
        @(negedge clk);
        {ag, bg, cg, dg} = 4'($urandom_range(0, 15));
        repeat (EXTRA + 1) @(negedge clk);
      end
      n_checks++;
      if (first_num !== W'(m_first) || second_num !== W'(m_second)) begin
        n_err++;
        $display("FAIL random_%0d got=%h/%h exp=%h/%h", i,
                 first_num, second_num, W'(m_first), W'(m_second));
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_operand();
    test_second_operand();
    test_done_lock();
    test_invalid_held();
    test_mid_reset();
    test_button_through_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
